// File: rtl/aes_keysched_ctrl_if.sv
// Handshake bundle between the AES-256 key-schedule controller, key loader, step unit and round pipeline.
// The controller side uses the slave modport; the surrounding environment uses master.
interface aes_keysched_ctrl_if;
    logic         key_valid;
    logic         key_ready;
    logic [31:0]  key_word;
    logic         step_req;
    logic [5:0]   step_idx;
    logic [31:0]  step_wPrev;
    logic [31:0]  step_wOld;
    logic         step_ack;
    logic [31:0]  step_word;
    logic         rk_req;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;
    logic         busy;
    logic         keys_ready;

    modport slave (
        input  key_valid, key_word, step_ack, step_word, rk_req, rk_round,
        output key_ready, step_req, step_idx, step_wPrev, step_wOld,
               rk_valid, rk_data, rk_err, busy, keys_ready
    );

    modport master (
        output key_valid, key_word, step_ack, step_word, rk_req, rk_round,
        input  key_ready, step_req, step_idx, step_wPrev, step_wOld,
               rk_valid, rk_data, rk_err, busy, keys_ready
    );
endinterface

// File: rtl/aes_keysched_ctrl.sv
// AES-256 key expansion sequencer and round-key store; optional KEYSCHED_ZEROIZE_EN adds a zeroize input.
// Latency: one step per cycle with zero-wait acks; round-key reads answer 1 cycle after rk_req, fully pipelined.
// Backpressure: key words stall on key_ready (low while expanding); steps hold stable until step_ack.
module aes_keysched_ctrl #(
    parameter int NK = 8,
    parameter int NR = 14,
    parameter int NB = 4
) (
    input  logic clk,
    input  logic resetn,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_keysched_ctrl_if.slave bus
);

    localparam int NW = NB * (NR + 1);
    localparam logic [2:0] LAST_KEY   = 3'(NK - 1);
    localparam logic [5:0] FIRST_STEP = 6'(NK);
    localparam logic [5:0] LAST_STEP  = 6'(NW - 1);
    localparam logic [5:0] OLD_LAG    = 6'(NK - 1);
    localparam logic [3:0] MAX_RND    = 4'(NR);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [5:0]     idx_q, idx_d;
    logic           step_req_q, step_req_d;
    logic [31:0]    wprev_q, wprev_d;
    logic [31:0]    wold_q, wold_d;
    logic           key_ready_q;
    logic           rk_valid_q, rk_err_q;
    logic [127:0]   rk_data_q;
    logic [31:0]    w_q [NW];

    logic           we;
    logic [5:0]     waddr;
    logic [31:0]    wdata;
    logic           key_acc, step_acc, zero_evt;
    logic           rk_ok;
    logic [5:0]     rd_base;
    logic [127:0]   rd_data;

`ifdef KEYSCHED_ZEROIZE_EN
    assign zero_evt = zeroize;
`else
    assign zero_evt = 1'b0;
`endif

    assign key_acc  = bus.key_valid & key_ready_q;
    assign step_acc = step_req_q & bus.step_ack;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        step_req_d = step_req_q;
        wprev_d    = wprev_q;
        wold_d     = wold_q;
        we         = 1'b0;
        waddr      = 6'd0;
        wdata      = bus.key_word;
        case (state_q)
            IDLE, READY: begin
                if (key_acc) begin
                    we      = 1'b1;
                    cnt_d   = 3'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (key_acc) begin
                    we    = 1'b1;
                    waddr = {3'b000, cnt_q};
                    cnt_d = cnt_q + 3'd1;
                    // The word being accepted is w[NK-1]; forward it straight into the first step.
                    if (cnt_q == LAST_KEY) begin
                        state_d    = EXPAND;
                        step_req_d = 1'b1;
                        idx_d      = FIRST_STEP;
                        wprev_d    = bus.key_word;
                        wold_d     = w_q[0];
                    end
                end
            end
            EXPAND: begin
                if (step_acc) begin
                    we    = 1'b1;
                    waddr = idx_q;
                    wdata = bus.step_word;
                    if (idx_q == LAST_STEP) begin
                        state_d    = READY;
                        step_req_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        wprev_d = bus.step_word;
                        wold_d  = w_q[idx_q - OLD_LAG];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (zero_evt) begin
            state_d    = IDLE;
            step_req_d = 1'b0;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= 6'd0;
            step_req_q  <= 1'b0;
            wprev_q     <= 32'd0;
            wold_q      <= 32'd0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            step_req_q  <= step_req_d;
            wprev_q     <= wprev_d;
            wold_q      <= wold_d;
            key_ready_q <= (state_d != EXPAND);
        end
    end

    always_ff @(posedge clk) begin
        if (zero_evt) begin
            for (int i = 0; i < NW; i++) begin
                w_q[i] <= 32'd0;
            end
        end else if (we) begin
            w_q[waddr] <= wdata;
        end
    end

    // Lookup uses pre-edge state, so a read racing a new key still sees the old schedule.
    assign rk_ok   = (state_q == READY) && (bus.rk_round <= MAX_RND) && !zero_evt;
    assign rd_base = rk_ok ? {bus.rk_round, 2'b00} : 6'd0;
    assign rd_data = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_data_q  <= 128'd0;
        end else if (bus.rk_req) begin
            rk_valid_q <= 1'b1;
            rk_err_q   <= !rk_ok;
            rk_data_q  <= rk_ok ? rd_data : 128'd0;
        end else begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.step_req   = step_req_q;
    assign bus.step_idx   = idx_q;
    assign bus.step_wPrev = wprev_q;
    assign bus.step_wOld  = wold_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_err     = rk_err_q;
    assign bus.rk_data    = rk_data_q;
    assign bus.busy       = (state_q == LOAD) || (state_q == EXPAND);
    assign bus.keys_ready = (state_q == READY);

endmodule

// File: tb/tb_aes_keysched_ctrl.sv
// Bench for aes_keysched_ctrl: behavioural AES-256 step unit and key-expansion model, round-key scoreboard.
module tb_aes_keysched_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aes_keysched_ctrl_if bus();
`ifdef KEYSCHED_ZEROIZE_EN
    logic zeroize = 1'b0;
`endif

    aes_keysched_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  sbox [256];
    logic [31:0] key_w [8];
    logic [31:0] fips_w [8];
    logic [31:0] ref_w [60];

    typedef struct {
        int           cyc;
        logic         err;
        logic [127:0] data;
    } rk_exp_t;
    rk_exp_t sb[$];

    int ack_delay = 0;
    int exp_idx = 8;
    bit force_ack = 1'b0;

    localparam logic [127:0] FIPS_R1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_R2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] FIPS_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'd0;
            logic [7:0] av = 8'(a);
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] step_fn(input int i, input logic [31:0] prev, input logic [31:0] old);
        logic [31:0] t = prev;
        logic [7:0]  rc = 8'h01 << (i / 8 - 1);
        if (i % 8 == 0) t = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
        else if (i % 8 == 4) t = sub_word(prev);
        return old ^ t;
    endfunction

    task automatic expand();
        for (int i = 0; i < 8; i++) ref_w[i] = key_w[i];
        for (int i = 8; i < 60; i++) ref_w[i] = step_fn(i, ref_w[i-1], ref_w[i-8]);
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // Behavioural step unit: acks after ack_delay waiting cycles, checks operand stability.
    initial begin : step_model
        bit          pend;
        int          pidx;
        int          waitc;
        logic [31:0] pprev, pold;
        pend = 1'b0; pidx = 0; waitc = 0; pprev = '0; pold = '0;
        bus.step_ack = 1'b0;
        bus.step_word = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus.step_ack = 1'b0;
            if (force_ack) begin
                bus.step_ack = 1'b1;
                bus.step_word = 32'hdeadbeef;
                pend = 1'b0;
            end else if (bus.step_req) begin
                if (!pend || int'(bus.step_idx) != pidx) begin
                    pend = 1'b1; pidx = int'(bus.step_idx); waitc = 0;
                    pprev = bus.step_wPrev; pold = bus.step_wOld;
                    chk("step_idx_seq", bus.step_idx, exp_idx);
                    if (pidx >= 8 && pidx < 60) begin
                        chk("step_wPrev", pprev, ref_w[pidx-1]);
                        chk("step_wOld", pold, ref_w[pidx-8]);
                    end
                end else begin
                    chk("step_wPrev_stable", bus.step_wPrev, pprev);
                    chk("step_wOld_stable", bus.step_wOld, pold);
                end
                if (waitc >= ack_delay) begin
                    bus.step_ack = 1'b1;
                    bus.step_word = step_fn(pidx, pprev, pold);
                    pend = 1'b0;
                    exp_idx++;
                end else begin
                    waitc++;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // Round-key response monitor.
    initial begin : rk_monitor
        logic [127:0] last;
        rk_exp_t e;
        last = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rk_valid_in_reset", bus.rk_valid, 1'b0);
                last = '0;
            end else if (bus.rk_valid) begin
                if (sb.size() == 0) begin
                    chk("rk_unexpected", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rk_latency", cyc, e.cyc);
                    chk("rk_err", bus.rk_err, e.err);
                    chk("rk_data", bus.rk_data, e.data);
                end
                last = bus.rk_data;
            end else begin
                chk("rk_data_hold", bus.rk_data, last);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("rk_missing", 1'b0, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic rk_read(input int r, input logic err, input logic [127:0] data);
        bus.rk_req = 1'b1;
        bus.rk_round = 4'(r);
        sb.push_back('{cyc + 1, err, data});
        @(posedge clk); #1;
        bus.rk_req = 1'b0;
    endtask

    task automatic rk_read_model(input int r);
        if (r <= 14) rk_read(r, 1'b0, ref_rk(r));
        else rk_read(r, 1'b1, 128'd0);
    endtask

    task automatic load_key(input int start, input int gapmax);
        for (int i = start; i < 8; i++) begin
            int gap = $urandom_range(0, gapmax);
            int t = 0;
            bit acc = 1'b0;
            if (gap > 0) begin
                bus.key_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            bus.key_valid = 1'b1;
            bus.key_word = key_w[i];
            while (!acc) begin
                acc = bus.key_ready;
                @(posedge clk); #1;
                t++;
                if (t > 200) begin
                    chk("key_accept_timeout", 1'b0, 1'b1);
                    break;
                end
            end
        end
        bus.key_valid = 1'b0;
        chk("busy_expand", bus.busy, 1'b1);
        chk("key_ready_expand", bus.key_ready, 1'b0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.keys_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("keys_ready_seen", bus.keys_ready, 1'b1);
        chk("busy_ready", bus.busy, 1'b0);
        chk("key_ready_ready", bus.key_ready, 1'b1);
    endtask

    task automatic read_all();
        for (int r = 0; r <= 15; r++) begin
            rk_read_model(r);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
    endtask

    initial begin : main
        int n;
        int r;
        logic [127:0] old_rk;
        bus.key_valid = 1'b0; bus.key_word = 32'd0;
        bus.rk_req = 1'b0; bus.rk_round = 4'd0;
        build_sbox();
        for (int i = 0; i < 8; i++) begin
            fips_w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            key_w[i] = fips_w[i];
        end
        expand();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", bus.key_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_keys_ready", bus.keys_ready, 1'b0);
        chk("rst_step_req", bus.step_req, 1'b0);
        chk("rst_rk_err", bus.rk_err, 1'b0);
        chk("rst_rk_data", bus.rk_data, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("key_ready_at_deassert", bus.key_ready, 1'b0);
        @(posedge clk); #1;
        chk("key_ready_after_deassert", bus.key_ready, 1'b1);

        // FIPS key, zero-wait steps
        ack_delay = 0; exp_idx = 8;
        load_key(0, 0);
        wait_ready(n);
        chk("ready_latency", n, 52);
        chk("step_count", exp_idx, 60);
        rk_read(1, 1'b0, FIPS_R1);
        rk_read(2, 1'b0, FIPS_R2);
        @(posedge clk); #1;
        rk_read(14, 1'b0, FIPS_R14);
        rk_read(15, 1'b1, 128'd0);
        repeat (20) begin
            rk_read_model($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // New random key accepted in READY with a racing read of the old key
        r = $urandom_range(0, 14);
        old_rk = ref_rk(r);
        for (int i = 0; i < 8; i++) key_w[i] = $urandom;
        expand();
        ack_delay = 3; exp_idx = 8;
        bus.rk_req = 1'b1; bus.rk_round = 4'(r);
        sb.push_back('{cyc + 1, 1'b0, old_rk});
        bus.key_valid = 1'b1; bus.key_word = key_w[0];
        @(posedge clk); #1;
        bus.rk_req = 1'b0;
        chk("keys_ready_drop", bus.keys_ready, 1'b0);
        chk("busy_load", bus.busy, 1'b1);
        load_key(1, 2);
        wait_ready(n);
        read_all();

        // FIPS key again, delayed acks and key gaps
        for (int i = 0; i < 8; i++) key_w[i] = fips_w[i];
        expand();
        ack_delay = 3; exp_idx = 8;
        load_key(0, 3);
        wait_ready(n);
        rk_read(1, 1'b0, FIPS_R1);
        rk_read(2, 1'b0, FIPS_R2);
        rk_read(14, 1'b0, FIPS_R14);
        read_all();

        // Reset during expansion, stray ack, reload
        ack_delay = 1; exp_idx = 8;
        load_key(0, 0);
        n = 0;
        while (!(bus.step_req && bus.step_idx == 6'd20) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_idx20", bus.step_idx, 6'd20);
        resetn = 1'b0;
        #1;
        chk("abort_step_req", bus.step_req, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        @(negedge clk);
        force_ack = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset_step_req", bus.step_req, 1'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_ack_busy", bus.busy, 1'b0);
        chk("stray_ack_step_req", bus.step_req, 1'b0);
        chk("stray_ack_keys_ready", bus.keys_ready, 1'b0);
        chk("idle_key_ready", bus.key_ready, 1'b1);
        rk_read(3, 1'b1, 128'd0);
        ack_delay = 2; exp_idx = 8;
        load_key(0, 1);
        rk_read(0, 1'b1, 128'd0);
        wait_ready(n);
        read_all();

`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b1;
        bus.rk_req = 1'b1; bus.rk_round = 4'd0;
        sb.push_back('{cyc + 1, 1'b1, 128'd0});
        @(posedge clk); #1;
        zeroize = 1'b0;
        bus.rk_req = 1'b0;
        chk("zeroize_keys_ready", bus.keys_ready, 1'b0);
        chk("zeroize_key_ready", bus.key_ready, 1'b1);
        chk("zeroize_busy", bus.busy, 1'b0);
        rk_read(0, 1'b1, 128'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
